sys_bridge_rmw: RTL and testbench

- Parametrised, sequential successor to the CPU-to-peripheral bridge.
- Sits between the M-stage data port and N memory-mapped devices laid out in uniform address slots.
- Registers each access, performs hardware read-modify-write for partial (byte/half) stores, and returns a default word on unmapped reads.
- Synchronises and masks device interrupts into the 6-bit HWInt vector through an internal mask register.

---
 rtl/sys_bridge_rmw.sv | 208 ++++++++++++++++++++
 tb/tb_sys_bridge_rmw.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sys_bridge_rmw.sv
// Sequential CPU-to-peripheral bridge with hardware read-modify-write for
// partial stores, a default word on unmapped loads, and a synchronised,
// maskable interrupt vector.
module sys_bridge_rmw #(
  parameter int          NUM_DEV    = 6,
  parameter logic [31:0] BASE_ADDR  = 32'h00007f00,
  parameter int          SLOT_BITS  = 4,
  parameter int          NUM_IRQ    = 2,
  parameter logic [31:0] DEFAULT_RD = 32'h16231138
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pr_req,
  input  logic                   pr_we,
  input  logic [31:0]            pr_addr,
  input  logic [31:0]            pr_wd,
  input  logic [3:0]             pr_be,
  output logic [31:0]            pr_rd,
  output logic                   pr_ready,
  output logic [NUM_DEV-1:0]     dev_sel,
  output logic [SLOT_BITS-1:0]   dev_addr,
  output logic                   dev_we,
  output logic [31:0]            dev_wd,
  input  logic [NUM_DEV*32-1:0]  dev_rd,
  input  logic [NUM_IRQ-1:0]     irq_in,
  output logic [5:0]             hw_int
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_MERGE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Access state and latched request
  logic [1:0]           state_q,    state_d;
  logic [3:0]           slot_q,     slot_d;
  logic [SLOT_BITS-1:0] offs_q,     offs_d;
  logic [31:0]          wd_q,       wd_d;
  logic [3:0]           be_q,       be_d;
  logic                 we_q,       we_d;
  logic                 hit_dev_q,  hit_dev_d;
  logic                 hit_mask_q, hit_mask_d;
  logic [31:0]          merged_q,   merged_d;
  logic [31:0]          pr_rd_q,    pr_rd_d;

  // Interrupt path
  logic [NUM_IRQ-1:0]   irq_mask_q, irq_mask_d;
  logic [NUM_IRQ-1:0]   sync1_q,    sync1_d;
  logic [NUM_IRQ-1:0]   sync2_q,    sync2_d;
  logic [5:0]           hw_int_q,   hw_int_d;

  // Address decode of the incoming request
  logic [31:0] off_w;
  logic [31:0] slot_w;
  logic        in_range_w;
  logic        dec_dev_w;
  logic        dec_mask_w;

  assign off_w      = pr_addr - BASE_ADDR;
  assign slot_w     = off_w >> SLOT_BITS;
  assign in_range_w = (pr_addr >= BASE_ADDR);
  assign dec_dev_w  = in_range_w && (slot_w < 32'(NUM_DEV));
  assign dec_mask_w = in_range_w && (slot_w == 32'(NUM_DEV)) &&
                      (off_w[SLOT_BITS-1:2] == '0);

  // Read data of the latched slot, and the merged word for partial stores
  logic [31:0] sel_rd_w;
  logic [31:0] merged_w;

  // Select the addressed device's read word
  always_comb begin
    sel_rd_w = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (slot_q == 4'(i)) sel_rd_w = dev_rd[32*i +: 32];
    end
  end

  // Byte-lane merge: enabled lanes from the store, others from the device
  always_comb begin
    merged_w = '0;
    for (int k = 0; k < 4; k++) begin
      merged_w[8*k +: 8] = be_q[k] ? wd_q[8*k +: 8] : sel_rd_w[8*k +: 8];
    end
  end

  // Access FSM next-state and datapath latch logic
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    offs_d     = offs_q;
    wd_d       = wd_q;
    be_d       = be_q;
    we_d       = we_q;
    hit_dev_d  = hit_dev_q;
    hit_mask_d = hit_mask_q;
    merged_d   = merged_q;
    pr_rd_d    = pr_rd_q;
    irq_mask_d = irq_mask_q;
    case (state_q)
      S_IDLE: begin
        if (pr_req) begin
          slot_d     = slot_w[3:0];
          offs_d     = off_w[SLOT_BITS-1:0];
          wd_d       = pr_wd;
          be_d       = pr_be;
          we_d       = pr_we;
          hit_dev_d  = dec_dev_w;
          hit_mask_d = dec_mask_w;
          state_d    = S_ACCESS;
        end
      end
      S_ACCESS: begin
        state_d = S_DONE;
        if (hit_dev_q) begin
          if (!we_q) begin
            pr_rd_d = sel_rd_w;
          end else if ((be_q != 4'hF) && (be_q != 4'h0)) begin
            // Partial store: read this cycle, write the merged word next
            merged_d = merged_w;
            state_d  = S_MERGE;
          end
        end else if (hit_mask_q) begin
          if (we_q) begin
            if (be_q[0]) irq_mask_d = wd_q[NUM_IRQ-1:0];
          end else begin
            pr_rd_d = 32'(irq_mask_q);
          end
        end else begin
          if (!we_q) pr_rd_d = DEFAULT_RD;
        end
      end
      S_MERGE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Interrupt synchroniser and masked vector
  always_comb begin
    sync1_d  = irq_in;
    sync2_d  = sync1_q;
    hw_int_d = 6'(sync2_q & irq_mask_q);
  end

  // Access state registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      slot_q     <= '0;
      offs_q     <= '0;
      wd_q       <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      hit_dev_q  <= 1'b0;
      hit_mask_q <= 1'b0;
      merged_q   <= '0;
      pr_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      offs_q     <= offs_d;
      wd_q       <= wd_d;
      be_q       <= be_d;
      we_q       <= we_d;
      hit_dev_q  <= hit_dev_d;
      hit_mask_q <= hit_mask_d;
      merged_q   <= merged_d;
      pr_rd_q    <= pr_rd_d;
    end
  end

  // Interrupt registers; mask comes up fully enabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask_q <= '1;
      sync1_q    <= '0;
      sync2_q    <= '0;
      hw_int_q   <= '0;
    end else begin
      irq_mask_q <= irq_mask_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      hw_int_q   <= hw_int_d;
    end
  end

  // Device-side strobes derived from state and the latched request
  logic dev_active_w;
  logic full_wr_w;

  assign dev_active_w = hit_dev_q && ((state_q == S_ACCESS) || (state_q == S_MERGE));
  assign full_wr_w    = (state_q == S_ACCESS) && hit_dev_q && we_q && (be_q == 4'hF);

  // One-hot select of the latched slot while the device is being accessed
  always_comb begin
    dev_sel = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_sel[i] = dev_active_w && (slot_q == 4'(i));
    end
  end

  assign dev_we   = full_wr_w || (state_q == S_MERGE);
  assign dev_wd   = (state_q == S_MERGE) ? merged_q : (full_wr_w ? wd_q : '0);
  assign dev_addr = offs_q;
  assign pr_ready = (state_q == S_DONE);
  assign pr_rd    = pr_rd_q;
  assign hw_int   = hw_int_q;

endmodule

// File: tb/tb_sys_bridge_rmw.sv
// Scoreboard bench for sys_bridge_rmw: stimulus pushes expected device writes
// and CPU responses; a negedge monitor pops and compares them.
module tb_sys_bridge_rmw;

  localparam int NUM_DEV   = 6;
  localparam int SLOT_BITS = 4;
  localparam int NUM_IRQ   = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  pr_req;
  logic                  pr_we;
  logic [31:0]           pr_addr;
  logic [31:0]           pr_wd;
  logic [3:0]            pr_be;
  logic [31:0]           pr_rd;
  logic                  pr_ready;
  logic [NUM_DEV-1:0]    dev_sel;
  logic [SLOT_BITS-1:0]  dev_addr;
  logic                  dev_we;
  logic [31:0]           dev_wd;
  logic [NUM_DEV*32-1:0] dev_rd;
  logic [NUM_IRQ-1:0]    irq_in;
  logic [5:0]            hw_int;

  sys_bridge_rmw dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .pr_req   (pr_req),
    .pr_we    (pr_we),
    .pr_addr  (pr_addr),
    .pr_wd    (pr_wd),
    .pr_be    (pr_be),
    .pr_rd    (pr_rd),
    .pr_ready (pr_ready),
    .dev_sel  (dev_sel),
    .dev_addr (dev_addr),
    .dev_we   (dev_we),
    .dev_wd   (dev_wd),
    .dev_rd   (dev_rd),
    .irq_in   (irq_in),
    .hw_int   (hw_int)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic nosel = 1'b0;

  typedef struct packed {
    logic [31:0] rd;
    logic        chk_rd;
    logic [31:0] issue;
    logic [31:0] lat;
  } rsp_t;

  typedef struct packed {
    logic [5:0]  sel;
    logic [3:0]  addr;
    logic [31:0] wd;
  } wr_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t mon_r;
  wr_t  mon_w;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every device write and every CPU completion
  always @(negedge clk) begin
    if (dev_we) begin
      if (wr_q.size() == 0) begin
        chk("unexpected_dev_we", 32'(dev_we), 32'd0);
      end else begin
        mon_w = wr_q.pop_front();
        chk("dev_sel_wr", 32'(dev_sel), 32'(mon_w.sel));
        chk("dev_addr_wr", 32'(dev_addr), 32'(mon_w.addr));
        chk("dev_wd", dev_wd, mon_w.wd);
      end
    end
    if (pr_ready) begin
      if (rsp_q.size() == 0) begin
        chk("unexpected_pr_ready", 32'(pr_ready), 32'd0);
      end else begin
        mon_r = rsp_q.pop_front();
        if (mon_r.chk_rd) chk("pr_rd", pr_rd, mon_r.rd);
        chk("latency", 32'(cyc) - mon_r.issue, mon_r.lat);
        chk("dev_we_count", 32'(wr_q.size()), 32'd0);
        chk("dev_sel_done", 32'(dev_sel), 32'd0);
      end
    end
    if (nosel) chk("dev_sel_miss", 32'(dev_sel), 32'd0);
  end

  // One CPU access with its expected response and optional expected write
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic chk_rd, input logic [31:0] rd,
                        input logic [31:0] lat, input logic has_wr, input logic [5:0] sel,
                        input logic [3:0] waddr, input logic [31:0] wwd);
    logic done;
    @(negedge clk);
    if (has_wr) wr_q.push_back('{sel: sel, addr: waddr, wd: wwd});
    rsp_q.push_back('{rd: rd, chk_rd: chk_rd, issue: 32'(cyc), lat: lat});
    pr_we   = we;
    pr_addr = addr;
    pr_wd   = wd;
    pr_be   = be;
    pr_req  = 1'b1;
    done    = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (pr_ready) done = 1'b1;
    end
    pr_req = 1'b0;
    if (!done) chk("pr_ready_timeout", 32'(pr_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    pr_req  = 1'b0;
    pr_we   = 1'b0;
    pr_addr = '0;
    pr_wd   = '0;
    pr_be   = '0;
    irq_in  = 2'b11;
    dev_rd  = {32'hA0000005, 32'hA0000004, 32'h11223344,
               32'hA0000002, 32'hA0000001, 32'hA0000000};

    // Reset state with interrupts asserted
    repeat (3) @(negedge clk);
    chk("rst_pr_rd", pr_rd, 32'd0);
    chk("rst_pr_ready", 32'(pr_ready), 32'd0);
    chk("rst_dev_sel", 32'(dev_sel), 32'd0);
    chk("rst_dev_we", 32'(dev_we), 32'd0);
    chk("rst_dev_wd", dev_wd, 32'd0);
    chk("rst_dev_addr", 32'(dev_addr), 32'd0);
    chk("rst_hw_int", 32'(hw_int), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hw_int_2clk", 32'(hw_int), 32'd0);
    @(negedge clk);
    chk("hw_int_3clk", 32'(hw_int), 32'h03);

    // Full store to slot 1, offset 4
    access(1'b1, 32'h00007f14, 32'hDEADBEEF, 4'b1111, 1'b0, 32'd0, 32'd2,
           1'b1, 6'b000010, 4'd4, 32'hDEADBEEF);
    // Byte store to slot 3: read-modify-write
    access(1'b1, 32'h00007f30, 32'h0000AA00, 4'b0010, 1'b0, 32'd0, 32'd3,
           1'b1, 6'b001000, 4'd0, 32'h1122AA44);
    // Upper-half store to slot 5, offset 12
    access(1'b1, 32'h00007f5c, 32'hBEEF0000, 4'b1100, 1'b0, 32'd0, 32'd3,
           1'b1, 6'b100000, 4'd12, 32'hBEEF0005);
    // Loads from slots 2 and 3
    access(1'b0, 32'h00007f28, 32'd0, 4'b1111, 1'b1, 32'hA0000002, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    access(1'b0, 32'h00007f30, 32'd0, 4'b1111, 1'b1, 32'h11223344, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    // Empty store: no write
    access(1'b1, 32'h00007f00, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'd0, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);

    // Unmapped accesses above and below the device window
    nosel = 1'b1;
    access(1'b0, 32'h00008000, 32'd0, 4'b1111, 1'b1, 32'h16231138, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    access(1'b0, 32'h00007e00, 32'd0, 4'b1111, 1'b1, 32'h16231138, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    access(1'b1, 32'h00008000, 32'h12345678, 4'b1111, 1'b0, 32'd0, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    nosel = 1'b0;

    // Mask register: default read, write 1, effect on hw_int, read back
    access(1'b0, 32'h00007f60, 32'd0, 4'b1111, 1'b1, 32'h00000003, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    access(1'b1, 32'h00007f60, 32'h00000001, 4'b0001, 1'b0, 32'd0, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    chk("hw_int_at_done", 32'(hw_int), 32'h03);
    @(negedge clk);
    chk("hw_int_masked", 32'(hw_int), 32'h01);
    access(1'b0, 32'h00007f60, 32'd0, 4'b1111, 1'b1, 32'h00000001, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    // Mask store without be[0] leaves mask unchanged
    access(1'b1, 32'h00007f60, 32'h00000003, 4'b0010, 1'b0, 32'd0, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);
    access(1'b0, 32'h00007f60, 32'd0, 4'b1111, 1'b1, 32'h00000001, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);

    // Reset during ACCESS of a partial store aborts it
    @(negedge clk);
    pr_we   = 1'b1;
    pr_addr = 32'h00007f30;
    pr_wd   = 32'h000000FF;
    pr_be   = 4'b0001;
    pr_req  = 1'b1;
    @(negedge clk);
    reset_n = 1'b0;
    pr_req  = 1'b0;
    #1;
    chk("abort_dev_we", 32'(dev_we), 32'd0);
    chk("abort_dev_sel", 32'(dev_sel), 32'd0);
    chk("abort_pr_ready", 32'(pr_ready), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    // Bridge is idle again: a fresh load completes normally
    access(1'b0, 32'h00007f10, 32'd0, 4'b1111, 1'b1, 32'hA0000001, 32'd2,
           1'b0, 6'd0, 4'd0, 32'd0);

    repeat (3) @(negedge clk);
    chk("rsp_q_drained", 32'(rsp_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
